// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the multiply/divide issue controller: D-stage op codes,
// E-stage unit/HI/LO select codes, FSM states and the watchdog default.
package md_issue_ctrl_pkg;

    localparam logic [3:0] MD_OP_NONE  = 4'd0;
    localparam logic [3:0] MD_OP_MULT  = 4'd1;
    localparam logic [3:0] MD_OP_MULTU = 4'd2;
    localparam logic [3:0] MD_OP_DIV   = 4'd3;
    localparam logic [3:0] MD_OP_DIVU  = 4'd4;
    localparam logic [3:0] MD_OP_MFHI  = 4'd5;
    localparam logic [3:0] MD_OP_MFLO  = 4'd6;
    localparam logic [3:0] MD_OP_MTHI  = 4'd7;
    localparam logic [3:0] MD_OP_MTLO  = 4'd8;

    localparam logic [2:0] HILOOP_MULT  = 3'b000;
    localparam logic [2:0] HILOOP_MULTU = 3'b001;
    localparam logic [2:0] HILOOP_DIV   = 3'b010;
    localparam logic [2:0] HILOOP_DIVU  = 3'b011;
    localparam logic [2:0] HILOOP_NONE  = 3'b111;

    localparam logic [1:0] HILO_SEL_HI   = 2'b00;
    localparam logic [1:0] HILO_SEL_LO   = 2'b01;
    localparam logic [1:0] HILO_SEL_NONE = 2'b11;

    localparam int WDOG_LIMIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUED,
        ST_WAIT
    } md_state_t;

    typedef struct packed {
        logic       start;
        logic [2:0] hiloop;
        logic [1:0] whilo;
        logic [1:0] hilosel;
    } md_ctrl_t;

    localparam md_ctrl_t MD_CTRL_BUBBLE = '{
        start:   1'b0,
        hiloop:  HILOOP_NONE,
        whilo:   HILO_SEL_NONE,
        hilosel: HILO_SEL_NONE
    };

    // Codes 9-15 are reserved and behave exactly like "no op".
    function automatic logic is_md_op(input logic valid, input logic [3:0] op);
        return valid && (op >= MD_OP_MULT) && (op <= MD_OP_MTLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// D/E pipeline handshake between the decode stage, the mult/div unit and the
// issue controller.
interface md_issue_ctrl_if;

    logic [3:0] md_op_D;
    logic       valid_D;
    logic       busy_E;
    logic       stall_D;
    logic       start_E;
    logic [2:0] hiloop_E;
    logic [1:0] whilo_E;
    logic [1:0] hilosel_E;

    modport master (
        output md_op_D, valid_D, busy_E,
        input  stall_D, start_E, hiloop_E, whilo_E, hilosel_E
    );

    modport slave (
        input  md_op_D, valid_D, busy_E,
        output stall_D, start_E, hiloop_E, whilo_E, hilosel_E
    );

endinterface

// File: rtl/md_issue_ctrl_decode.sv
// Pure combinational map from a D-stage md op to the E-stage control fields;
// anything that is not an md op decodes to the all-none bubble.
module md_decode
    import md_issue_ctrl_pkg::*;
(
    input  logic       valid,
    input  logic [3:0] md_op,
    output md_ctrl_t   ctrl
);

    always_comb begin
        ctrl = MD_CTRL_BUBBLE;
        if (valid) begin
            case (md_op)
                MD_OP_MULT:  begin ctrl.start = 1'b1; ctrl.hiloop = HILOOP_MULT;  end
                MD_OP_MULTU: begin ctrl.start = 1'b1; ctrl.hiloop = HILOOP_MULTU; end
                MD_OP_DIV:   begin ctrl.start = 1'b1; ctrl.hiloop = HILOOP_DIV;   end
                MD_OP_DIVU:  begin ctrl.start = 1'b1; ctrl.hiloop = HILOOP_DIVU;  end
                MD_OP_MFHI:  ctrl.hilosel = HILO_SEL_HI;
                MD_OP_MFLO:  ctrl.hilosel = HILO_SEL_LO;
                MD_OP_MTHI:  ctrl.whilo   = HILO_SEL_HI;
                MD_OP_MTLO:  ctrl.whilo   = HILO_SEL_LO;
                default:     ctrl = MD_CTRL_BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: holds D while a mult/div is in
// flight or the unit is busy, registers the E-stage controls and runs a watchdog.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    md_issue_ctrl_if.slave     bus,
    output logic               err_timeout,
    output logic [15:0]        stall_cnt
);

    localparam logic [3:0] WDOG_LIMIT_CNT = 4'(WDOG_LIMIT);

    md_state_t  state, state_next;
    logic [3:0] wdog_cnt, wdog_next, wdog_inc;
    logic       err_next;
    logic       md_op_valid;
    logic       stall;
    md_ctrl_t   dec_ctrl, e_ctrl, e_next;

    md_decode u_decode (
        .valid (bus.valid_D),
        .md_op (bus.md_op_D),
        .ctrl  (dec_ctrl)
    );

    assign md_op_valid = is_md_op(bus.valid_D, bus.md_op_D);
    assign stall       = md_op_valid && ((state != ST_IDLE) || bus.busy_E);
    assign wdog_inc    = wdog_cnt + 4'd1;

    assign bus.stall_D   = stall;
    assign bus.start_E   = e_ctrl.start;
    assign bus.hiloop_E  = e_ctrl.hiloop;
    assign bus.whilo_E   = e_ctrl.whilo;
    assign bus.hilosel_E = e_ctrl.hilosel;

    // ISSUED covers the cycle before the unit raises busy, so WAIT only has to
    // watch for busy falling or the watchdog expiring.
    always_comb begin
        state_next = state;
        wdog_next  = wdog_cnt;
        err_next   = err_timeout;
        e_next     = stall ? MD_CTRL_BUBBLE : dec_ctrl;
        case (state)
            ST_IDLE: begin
                if (!stall && dec_ctrl.start) state_next = ST_ISSUED;
            end
            ST_ISSUED: begin
                state_next = ST_WAIT;
                wdog_next  = '0;
            end
            ST_WAIT: begin
                wdog_next = wdog_inc;
                if (!bus.busy_E) begin
                    state_next = ST_IDLE;
                end else if (wdog_inc == WDOG_LIMIT_CNT) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
            e_ctrl      <= MD_CTRL_BUBBLE;
            stall_cnt   <= '0;
        end else begin
            state       <= state_next;
            wdog_cnt    <= wdog_next;
            err_timeout <= err_next;
            e_ctrl      <= e_next;
            if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: expected E-stage contents are queued when a
// D-stage op is driven and compared one cycle later when the registers show them.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_DIV = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_RSVD = 4'd12;

    logic        clk;
    logic        reset;
    logic        err_timeout;
    logic [15:0] stall_cnt;

    md_issue_ctrl_if bus ();

    md_issue_ctrl #(.WDOG_LIMIT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err_timeout (err_timeout),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passCount = 0;
    int          totalCount = 0;
    md_ctrl_t    sb[$];
    logic [15:0] expStallCnt = '0;
    logic        expErr = 1'b0;

    // Reference decode written straight from the op table, independent of the RTL.
    function automatic md_ctrl_t decodeModel(input logic [3:0] op, input logic valid);
        md_ctrl_t c;
        c = '{start: 1'b0, hiloop: 3'b111, whilo: 2'b11, hilosel: 2'b11};
        if (valid) begin
            case (op)
                4'd1: begin c.start = 1'b1; c.hiloop = 3'b000; end
                4'd2: begin c.start = 1'b1; c.hiloop = 3'b001; end
                4'd3: begin c.start = 1'b1; c.hiloop = 3'b010; end
                4'd4: begin c.start = 1'b1; c.hiloop = 3'b011; end
                4'd5: c.hilosel = 2'b00;
                4'd6: c.hilosel = 2'b01;
                4'd7: c.whilo   = 2'b00;
                4'd8: c.whilo   = 2'b01;
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkE(input string tag, input md_ctrl_t exp);
        checkOutput({tag, "/start_E"},   16'(bus.start_E),   16'(exp.start));
        checkOutput({tag, "/hiloop_E"},  16'(bus.hiloop_E),  16'(exp.hiloop));
        checkOutput({tag, "/whilo_E"},   16'(bus.whilo_E),   16'(exp.whilo));
        checkOutput({tag, "/hilosel_E"}, 16'(bus.hilosel_E), 16'(exp.hilosel));
    endtask

    task automatic checkResetValues(input string tag);
        checkE(tag, '{start: 1'b0, hiloop: 3'b111, whilo: 2'b11, hilosel: 2'b11});
        checkOutput({tag, "/err_timeout"}, 16'(err_timeout), 16'h0);
        checkOutput({tag, "/stall_cnt"},   stall_cnt,        16'h0);
    endtask

    // Drive one D-stage cycle, check mid-cycle, and queue the next E contents.
    task automatic applyStimulus(input logic [3:0] op, input logic valid, input logic busy,
                                 input logic expStall, input string tag);
        md_ctrl_t exp;
        bus.md_op_D = op;
        bus.valid_D = valid;
        bus.busy_E  = busy;
        @(negedge clk);
        checkOutput({tag, "/stall_D"},     16'(bus.stall_D), 16'(expStall));
        checkOutput({tag, "/stall_cnt"},   stall_cnt,        expStallCnt);
        checkOutput({tag, "/err_timeout"}, 16'(err_timeout), 16'(expErr));
        totalCount++;
        assert (sb.size() != 0) passCount++;
        else $error("[TB] FAIL %s/scoreboard observed=empty expected=entry", tag);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            checkE(tag, exp);
        end
        sb.push_back(expStall ? decodeModel(OP_NONE, 1'b0) : decodeModel(op, valid));
        if (expStall && (expStallCnt != 16'hFFFF)) expStallCnt = expStallCnt + 16'd1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] op, input logic valid, input logic busy,
                        input logic expStall, input string tag);
        applyStimulus(op, valid, busy, expStall, tag);
        nextCycle();
    endtask

    initial begin
        reset       = 1'b0;
        bus.md_op_D = OP_MULT;
        bus.valid_D = 1'b1;
        bus.busy_E  = 1'b1;
        #12;
        checkResetValues("reset");
        checkOutput("reset/stall_busy", 16'(bus.stall_D), 16'h1);
        bus.busy_E = 1'b0;
        #1;
        checkOutput("reset/stall_idle", 16'(bus.stall_D), 16'h0);
        bus.valid_D = 1'b0;
        bus.md_op_D = OP_NONE;
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        sb.push_back(decodeModel(OP_NONE, 1'b0));

        // mult issues, mflo waits out ISSUED and the busy window, then issues
        step(OP_MULT, 1'b1, 1'b0, 1'b0, "a0");
        step(OP_MFLO, 1'b1, 1'b0, 1'b1, "a1");
        for (int i = 2; i <= 6; i++) step(OP_MFLO, 1'b1, 1'b1, 1'b1, $sformatf("a%0d", i));
        step(OP_MFLO, 1'b1, 1'b0, 1'b1, "a7");
        step(OP_MFLO, 1'b1, 1'b0, 1'b0, "a8");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "a9");

        // move-to/from ops in IDLE, busy-only stall, reserved and invalid ops
        step(OP_MTHI, 1'b1, 1'b0, 1'b0, "c0");
        step(OP_MTHI, 1'b1, 1'b1, 1'b1, "c1");
        step(OP_RSVD, 1'b1, 1'b1, 1'b0, "c2");
        step(OP_MULT, 1'b0, 1'b1, 1'b0, "c3");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "c4");

        // back-to-back div then divu
        step(OP_DIV,  1'b1, 1'b0, 1'b0, "b0");
        step(OP_DIVU, 1'b1, 1'b0, 1'b1, "b1");
        step(OP_DIVU, 1'b1, 1'b1, 1'b1, "b2");
        step(OP_DIVU, 1'b1, 1'b1, 1'b1, "b3");
        step(OP_DIVU, 1'b1, 1'b0, 1'b1, "b4");
        step(OP_DIVU, 1'b1, 1'b0, 1'b0, "b5");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "b6");
        step(OP_NONE, 1'b0, 1'b1, 1'b0, "b7");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "b8");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "b9");

        // watchdog: busy stuck high for 20 cycles starting two cycles after issue
        step(OP_MULT, 1'b1, 1'b0, 1'b0, "d0");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "d1");
        for (int i = 2; i <= 15; i++) step(OP_NONE, 1'b0, 1'b1, 1'b0, $sformatf("d%0d", i));
        step(OP_MFLO, 1'b1, 1'b1, 1'b1, "d16");
        expErr = 1'b1;
        for (int i = 17; i <= 21; i++) step(OP_MFLO, 1'b1, 1'b1, 1'b1, $sformatf("d%0d", i));
        step(OP_MFLO, 1'b1, 1'b0, 1'b0, "d22");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "d23");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "d24");

        // asynchronous reset while in WAIT, then a fresh mult issues immediately
        step(OP_MULT, 1'b1, 1'b0, 1'b0, "e0");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "e1");
        step(OP_MULT, 1'b1, 1'b1, 1'b1, "e2");
        applyStimulus(OP_MULT, 1'b1, 1'b1, 1'b1, "e3");
        #1;
        bus.busy_E = 1'b0;
        reset      = 1'b0;
        #1;
        checkResetValues("e_rst");
        checkOutput("e_rst/stall_D", 16'(bus.stall_D), 16'h0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("e_rel/stall_D", 16'(bus.stall_D), 16'h0);
        sb.delete();
        sb.push_back(decodeModel(OP_MULT, 1'b1));
        expStallCnt = '0;
        expErr      = 1'b0;
        nextCycle();
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "e4");
        step(OP_MFLO, 1'b1, 1'b1, 1'b1, "e5");
        step(OP_MFLO, 1'b1, 1'b0, 1'b1, "e6");
        step(OP_MFLO, 1'b1, 1'b0, 1'b0, "e7");
        step(OP_NONE, 1'b0, 1'b0, 1'b0, "e8");

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
